// File: rtl/fb_arb.sv
// fb_arb: frame-buffer memory arbiter for one video reader and two camera writers.
// Reads win over writes; the two writers alternate round-robin. Each transaction
// moves BURST_LEN words and issues exactly one command to the memory controller.
// Optional watchdog: define FB_ARB_WDOG_EN to abort a data phase that stalls.
module fb_arb #(
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned ADDR_W    = 30
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CALIB_DONE_I,
    input  logic              REQ_RD_I,
    input  logic              REQ_WA_I,
    input  logic              REQ_WB_I,
    input  logic [ADDR_W-1:0] ADDR_RD_I,
    input  logic [ADDR_W-1:0] ADDR_WA_I,
    input  logic [ADDR_W-1:0] ADDR_WB_I,
    input  logic              XFER_I,
    input  logic              CMD_FULL_I,
    output logic              GNT_RD_O,
    output logic              GNT_WA_O,
    output logic              GNT_WB_O,
    output logic              CMD_EN_O,
    output logic [2:0]        CMD_INSTR_O,
    output logic [ADDR_W-1:0] CMD_ADDR_O,
    output logic [5:0]        CMD_BL_O,
    output logic              DONE_O,
    output logic              BUSY_O,
    output logic              ERR_O
);

    typedef enum logic [2:0] {StIdle, StWdata, StWcmd, StRcmd, StRdata} state_t;

    localparam logic [6:0] LastWord = 7'(BURST_LEN - 1);
    localparam logic [5:0] BlValue  = 6'(BURST_LEN - 1);

    state_t            state_q;
    logic              gnt_rd_q, gnt_wa_q, gnt_wb_q;
    logic [6:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rr_b_q;      // 1: writer B is favoured on a WA+WB tie
    logic              armed_q;     // low for the first edge after reset release
    logic              cmd_en_q;
    logic [2:0]        cmd_instr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [5:0]        cmd_bl_q;
    logic              done_q;
    logic              err_q;
    logic              wd_hit;

    logic in_data;
    logic req_any;
    logic pick_a;
    logic can_grant;

    assign in_data   = (state_q == StWdata) || (state_q == StRdata);
    assign req_any   = REQ_RD_I | REQ_WA_I | REQ_WB_I;
    assign pick_a    = REQ_WA_I && (!REQ_WB_I || !rr_b_q);
    // The DONE/ERR cycle is a forced idle cycle: no sampling there.
    assign can_grant = CALIB_DONE_I && armed_q && !done_q && !err_q;

`ifdef FB_ARB_WDOG_EN
    logic [11:0] wd_q;

    // Hit on the 4095th consecutive data-phase cycle without a word moved.
    assign wd_hit = in_data && !XFER_I && (wd_q == 12'd4094);

    // Watchdog counter and one-cycle error pulse.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= wd_hit;
            if (!in_data || XFER_I || wd_hit) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 12'd1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err_q  = 1'b0;
`endif

    // Arbitration FSM with all grant/command/status outputs registered.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= StIdle;
            gnt_rd_q    <= 1'b0;
            gnt_wa_q    <= 1'b0;
            gnt_wb_q    <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rr_b_q      <= 1'b0;
            armed_q     <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_instr_q <= 3'b000;
            cmd_addr_q  <= '0;
            cmd_bl_q    <= BlValue;
            done_q      <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            cmd_bl_q <= BlValue;
            cmd_en_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (can_grant && req_any) begin
                        cnt_q <= '0;
                        if (REQ_RD_I) begin
                            gnt_rd_q <= 1'b1;
                            addr_q   <= ADDR_RD_I;
                            state_q  <= StRcmd;
                        end else if (pick_a) begin
                            gnt_wa_q <= 1'b1;
                            addr_q   <= ADDR_WA_I;
                            state_q  <= StWdata;
                        end else begin
                            gnt_wb_q <= 1'b1;
                            addr_q   <= ADDR_WB_I;
                            state_q  <= StWdata;
                        end
                    end
                end
                StWdata: begin
                    if (wd_hit) begin
                        gnt_wa_q <= 1'b0;
                        gnt_wb_q <= 1'b0;
                        state_q  <= StIdle;
                    end else if (XFER_I) begin
                        cnt_q <= cnt_q + 7'd1;
                        if (cnt_q == LastWord) begin
                            state_q <= StWcmd;
                        end
                    end
                end
                StWcmd: begin
                    // Strobe first, then close the transaction on the following edge.
                    if (cmd_en_q) begin
                        done_q   <= 1'b1;
                        gnt_wa_q <= 1'b0;
                        gnt_wb_q <= 1'b0;
                        rr_b_q   <= ~rr_b_q;
                        state_q  <= StIdle;
                    end else if (!CMD_FULL_I) begin
                        cmd_en_q    <= 1'b1;
                        cmd_instr_q <= 3'b000;
                        cmd_addr_q  <= addr_q;
                    end
                end
                StRcmd: begin
                    if (!CMD_FULL_I) begin
                        cmd_en_q    <= 1'b1;
                        cmd_instr_q <= 3'b001;
                        cmd_addr_q  <= addr_q;
                        state_q     <= StRdata;
                    end
                end
                StRdata: begin
                    if (wd_hit) begin
                        gnt_rd_q <= 1'b0;
                        state_q  <= StIdle;
                    end else if (XFER_I) begin
                        cnt_q <= cnt_q + 7'd1;
                        if (cnt_q == LastWord) begin
                            done_q   <= 1'b1;
                            gnt_rd_q <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign GNT_RD_O    = gnt_rd_q;
    assign GNT_WA_O    = gnt_wa_q;
    assign GNT_WB_O    = gnt_wb_q;
    assign CMD_EN_O    = cmd_en_q;
    assign CMD_INSTR_O = cmd_instr_q;
    assign CMD_ADDR_O  = cmd_addr_q;
    assign CMD_BL_O    = cmd_bl_q;
    assign DONE_O      = done_q;
    assign BUSY_O      = (state_q != StIdle);
    assign ERR_O       = err_q;

endmodule
